om_alloc_tracker: RTL and testbench

//  Watches the commit stream for calls to the heap allocator and their matching returns.

---
 rtl/om_pkg.sv | 14 +
 rtl/om_sat_counter.sv | 23 ++
 rtl/om_alloc_tracker.sv | 128 ++++++++++++
 tb/tb_om_alloc_tracker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/om_pkg.sv
// Shared types and defaults for the allocation tracker slice.
package om_pkg;

    localparam int unsigned OM_ADDR_W = 32;
    localparam logic [OM_ADDR_W-1:0] OM_MALLOC_ADDR_DEF = 32'h0000_0000;
    localparam int unsigned OM_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitRet = 2'd1,
        StEmit    = 2'd2
    } om_trk_state_e;

endpackage

// File: rtl/om_sat_counter.sv
// Saturating up-counter, synchronous active-high clear.
module om_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/om_alloc_tracker.sv
// Pairs allocator calls with their returns and emits one [first,last] range write per allocation.
module om_alloc_tracker
    import om_pkg::*;
#(
    parameter logic [OM_ADDR_W-1:0] MALLOC_ADDR = OM_MALLOC_ADDR_DEF,
    parameter int unsigned          TIMEOUT     = OM_TIMEOUT_DEF,
    parameter int unsigned          CNT_W       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 commit_valid_i,
    input  logic [OM_ADDR_W-1:0] commit_pc_i,
    input  logic                 commit_is_call_i,
    input  logic                 commit_is_ret_i,
    input  logic [OM_ADDR_W-1:0] commit_target_i,
    input  logic [OM_ADDR_W-1:0] a0_i,
    output logic                 en_write_o,
    output logic [OM_ADDR_W-1:0] addr_first_o,
    output logic [OM_ADDR_W-1:0] addr_last_o,
    output logic                 busy_o,
    output logic                 clamp_o,
    output logic [CNT_W-1:0]     drop_cnt_o,
    output logic [CNT_W-1:0]     skip_cnt_o
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    om_trk_state_e          state_q, state_d;
    logic [OM_ADDR_W-1:0]   size_q, ret_addr_q, base_q;
    logic [TW-1:0]          timer_q;
    logic                   strobe_q, clamp_q, skip_q;
    logic [OM_ADDR_W-1:0]   first_q, last_q;

    logic                   call_hit, ret_hit, timeout, latch_call, take_ret;
    logic                   drop_inc, skip_inc;
    logic [OM_ADDR_W:0]     sum;

    assign call_hit = commit_valid_i && commit_is_call_i && (commit_target_i == MALLOC_ADDR);
    assign ret_hit  = commit_valid_i && commit_is_ret_i && (commit_target_i == ret_addr_q);
    assign timeout  = (timer_q == TIMER_LAST);
    assign take_ret = enable_i && (state_q == StWaitRet) && ret_hit;
    assign latch_call = enable_i && call_hit && ((state_q == StIdle) || (state_q == StEmit));
    assign sum      = {1'b0, a0_i} + {1'b0, size_q} - {{OM_ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (call_hit) state_d = StWaitRet;
                StWaitRet: begin
                    if (ret_hit) state_d = StEmit;
                    else if (timeout) state_d = StIdle;
                end
                StEmit:    state_d = call_hit ? StWaitRet : StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    // Aborts count once per pending allocation; a strobe already registered for EMIT is masked below.
    assign drop_inc = ((state_q != StIdle) && !enable_i)
                    || (enable_i && (state_q == StWaitRet) && timeout && !ret_hit);
    assign skip_inc = enable_i && (state_q == StEmit) && skip_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            size_q     <= '0;
            ret_addr_q <= '0;
            base_q     <= '0;
            timer_q    <= '0;
            strobe_q   <= 1'b0;
            clamp_q    <= 1'b0;
            skip_q     <= 1'b0;
            first_q    <= '0;
            last_q     <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= 1'b0;
            clamp_q  <= 1'b0;
            skip_q   <= 1'b0;
            if (state_q == StWaitRet) begin
                timer_q <= timer_q + TW'(1);
            end
            if (latch_call) begin
                size_q     <= a0_i;
                ret_addr_q <= commit_pc_i + 32'd4;
                timer_q    <= '0;
            end
            if (take_ret) begin
                base_q <= a0_i;
                if ((a0_i == '0) || (size_q == '0)) begin
                    skip_q <= 1'b1;
                end else begin
                    strobe_q <= 1'b1;
                    first_q  <= a0_i;
                    last_q   <= sum[OM_ADDR_W] ? {OM_ADDR_W{1'b1}} : sum[OM_ADDR_W-1:0];
                    clamp_q  <= sum[OM_ADDR_W];
                end
            end
        end
    end

    om_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt_o)
    );

    om_sat_counter #(.W(CNT_W)) u_skip_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (skip_inc),
        .cnt_o (skip_cnt_o)
    );

    assign en_write_o   = strobe_q && enable_i;
    assign clamp_o      = clamp_q && enable_i;
    assign addr_first_o = first_q;
    assign addr_last_o  = last_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_om_alloc_tracker.sv
// Directed bench for om_alloc_tracker with immediate-assertion checks.
module tb_om_alloc_tracker;

    localparam logic [31:0] MA = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst, enable, cv, is_call, is_ret;
    logic [31:0] pc, target, a0;
    logic        en_write, busy, clamp;
    logic [31:0] first, last;
    logic [7:0]  drop_cnt, skip_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    om_alloc_tracker #(.MALLOC_ADDR(MA), .TIMEOUT(8), .CNT_W(8)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .commit_valid_i   (cv),
        .commit_pc_i      (pc),
        .commit_is_call_i (is_call),
        .commit_is_ret_i  (is_ret),
        .commit_target_i  (target),
        .a0_i             (a0),
        .en_write_o       (en_write),
        .addr_first_o     (first),
        .addr_last_o      (last),
        .busy_o           (busy),
        .clamp_o          (clamp),
        .drop_cnt_o       (drop_cnt),
        .skip_cnt_o       (skip_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cv = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    endtask

    task automatic call(input logic [31:0] cpc, input logic [31:0] size);
        cv = 1'b1; is_call = 1'b1; is_ret = 1'b0; pc = cpc; target = MA; a0 = size;
        step();
    endtask

    task automatic ret(input logic [31:0] tgt, input logic [31:0] base);
        cv = 1'b1; is_call = 1'b0; is_ret = 1'b1; pc = 32'h0000_0040; target = tgt; a0 = base;
        step();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; cv = 1'b0; is_call = 1'b0; is_ret = 1'b0;
        pc = '0; target = '0; a0 = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_en", {31'b0, en_write}, 32'd0);
        chk("rst_first", first, 32'd0);
        chk("rst_last", last, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_clamp", {31'b0, clamp}, 32'd0);
        chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
        chk("rst_skip", {24'b0, skip_cnt}, 32'd0);

        // Basic allocation
        call(32'h100, 32'd16);
        chk("basic_busy", {31'b0, busy}, 32'd1);
        step();
        ret(32'h104, 32'h8000_0000);
        chk("basic_en", {31'b0, en_write}, 32'd1);
        chk("basic_first", first, 32'h8000_0000);
        chk("basic_last", last, 32'h8000_000F);
        chk("basic_clamp", {31'b0, clamp}, 32'd0);
        step();
        chk("basic_en_off", {31'b0, en_write}, 32'd0);
        chk("basic_idle", {31'b0, busy}, 32'd0);
        chk("basic_hold", first, 32'h8000_0000);

        // NULL base then zero size
        call(32'h100, 32'd16);
        ret(32'h104, 32'd0);
        chk("null_en", {31'b0, en_write}, 32'd0);
        step();
        chk("null_skip", {24'b0, skip_cnt}, 32'd1);
        chk("null_hold", last, 32'h8000_000F);
        call(32'h100, 32'd0);
        ret(32'h104, 32'h3000);
        chk("zero_en", {31'b0, en_write}, 32'd0);
        step();
        chk("zero_skip", {24'b0, skip_cnt}, 32'd2);

        // Foreign return and nested call ignored
        call(32'h100, 32'd16);
        ret(32'h500, 32'h7);
        chk("foreign_en", {31'b0, en_write}, 32'd0);
        chk("foreign_busy", {31'b0, busy}, 32'd1);
        call(32'h200, 32'd99);
        chk("nested_busy", {31'b0, busy}, 32'd1);
        ret(32'h104, 32'h1000);
        chk("nested_en", {31'b0, en_write}, 32'd1);
        chk("nested_first", first, 32'h1000);
        chk("nested_last", last, 32'h100F);
        step();

        // Timeout after 8 cycles in WAIT_RET
        call(32'h100, 32'd16);
        for (int i = 0; i < 7; i++) step();
        chk("to_busy7", {31'b0, busy}, 32'd1);
        step();
        chk("to_busy8", {31'b0, busy}, 32'd0);
        chk("to_drop", {24'b0, drop_cnt}, 32'd1);
        ret(32'h104, 32'h2000);
        chk("to_late_en", {31'b0, en_write}, 32'd0);
        step();

        // Clamp at top of address space
        call(32'h100, 32'h20);
        ret(32'h104, 32'hFFFF_FFF0);
        chk("clamp_en", {31'b0, en_write}, 32'd1);
        chk("clamp_first", first, 32'hFFFF_FFF0);
        chk("clamp_last", last, 32'hFFFF_FFFF);
        chk("clamp_flag", {31'b0, clamp}, 32'd1);
        step();
        chk("clamp_off", {31'b0, clamp}, 32'd0);

        // Back-to-back: call hit during EMIT
        call(32'h100, 32'd16);
        ret(32'h104, 32'h4000);
        chk("b2b_en1", {31'b0, en_write}, 32'd1);
        call(32'h300, 32'd8);
        chk("b2b_en_gap", {31'b0, en_write}, 32'd0);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        ret(32'h304, 32'h5000);
        chk("b2b_en2", {31'b0, en_write}, 32'd1);
        chk("b2b_first", first, 32'h5000);
        chk("b2b_last", last, 32'h5007);
        step();
        chk("b2b_idle", {31'b0, busy}, 32'd0);

        // Enable abort in WAIT_RET
        call(32'h100, 32'd16);
        enable = 1'b0;
        step();
        enable = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_drop", {24'b0, drop_cnt}, 32'd2);
        ret(32'h104, 32'h6000);
        chk("abort_en", {31'b0, en_write}, 32'd0);
        chk("abort_skip", {24'b0, skip_cnt}, 32'd2);

        // Reset mid-operation
        call(32'h100, 32'd16);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_first", first, 32'd0);
        chk("mrst_drop", {24'b0, drop_cnt}, 32'd0);
        chk("mrst_skip", {24'b0, skip_cnt}, 32'd0);

        // Enable low during EMIT suppresses strobe and counts a drop
        call(32'h100, 32'd16);
        ret(32'h104, 32'h9000);
        enable = 1'b0;
        #1;
        chk("emit_abort_en", {31'b0, en_write}, 32'd0);
        step();
        enable = 1'b1;
        chk("emit_abort_drop", {24'b0, drop_cnt}, 32'd1);
        chk("emit_abort_busy", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
